regfile_dump_reader: RTL and testbench
======================================

Name: regfile_dump_reader

Overview:
Read-side sweeper for the 2-read/1-write register file. On a start pulse it walks every register address in ascending pairs. It drives the read ports ra1 and ra2, and captures rd1 and rd2. It then streams each register value out as an (address, data) beat over a valid/ready interface, for debug readout, a UART transmitter or a checksum unit.

Parameters:
N, 8, register data width (matches register file N)
M, 3, address width; register count R = 2^M, M >= 1 so R is even

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low
start  input  1  1-cycle request to begin a sweep; sampled only in IDLE
abort  input  1  synchronous abort; returns to IDLE without done
ra1  output  M  register file read address 1 (even address of current pair)
ra2  output  M  register file read address 2 (odd address of current pair)
rd1  input  N  register file read data 1 (combinational from ra1)
rd2  input  N  register file read data 2 (combinational from ra2)
out_data  output  N  streamed register value
out_addr  output  M  address of streamed value
out_valid  output  1  beat valid
out_ready  input  1  downstream accepts beat
busy  output  1  high in any state except IDLE
done  output  1  1-cycle pulse after the last beat is accepted

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - ptr, buf0 and buf1 are cleared to 0.
  - ra1=0, ra2=1, out_data=0, out_addr=0, out_valid=0, busy=0, done=0.
  - Reset asserted mid-sweep kills the sweep immediately; no done.
- States: IDLE, FETCH, SEND0, SEND1, DONE.
- IDLE:
  - ra1=ptr(=0), ra2=ptr+1.
  - start=1 -> FETCH, ptr=0.
- FETCH:
  - ra1=ptr, ra2=ptr+1.
  - At the clock edge, buf0<=rd1 and buf1<=rd2 -> SEND0.
  - Register contents are sampled only here. Writes to the pair after this edge are not reflected in the current sweep.
- SEND0:
  - out_valid=1, out_data=buf0, out_addr=ptr.
  - out_ready=1 -> SEND1; otherwise hold.
- SEND1:
  - out_valid=1, out_data=buf1, out_addr=ptr+1.
  - On out_ready=1: if ptr+1 == R-1 -> DONE; else ptr<=ptr+2 -> FETCH.
- DONE: done=1 for exactly one cycle -> IDLE, ptr<=0.
- Handshake rules:
  - A beat transfers on a rising edge with out_valid=1 and out_ready=1.
  - While out_valid=1 and out_ready=0, out_data and out_addr are held stable.
  - out_valid never drops without a transfer, except on abort or reset.
- out_data and out_addr are registered (state-decoded from buf and ptr); they read 0 when out_valid=0.
- Latency:
  - start sampled at edge k -> FETCH during cycle k+1 -> first out_valid in cycle k+2.
  - With out_ready held high, each pair takes 3 cycles. A full sweep of R=8 takes 12 cycles from FETCH entry, plus 1 DONE cycle.
- start while busy is ignored; no queuing.
- abort=1 in any non-IDLE state:
  - Next state IDLE, ptr<=0, out_valid<=0, no done.
  - abort has priority over out_ready in the same cycle: the beat is not counted as transferred.
- ptr arithmetic is M bits. ptr+1 never wraps because ptr is always even and R is even. The termination test is on ptr+1 == R-1, not on overflow.
- No write ports are driven; the block never modifies the register file.

Test Plan:
- Basic sweep (N=8, M=3):
  - Stimulus: preload regs 0..7 with 8'h10..8'h17 via the write port; out_ready=1; pulse start.
  - Response: 8 beats of (addr,data) = (0,10h) .. (7,17h), one beat per cycle except one bubble cycle before each even address; done pulses one cycle after the beat (7,17h); busy is low afterwards.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles while in SEND0 with reg0=8'hAB.
  - Response: out_valid=1 and out_data=8'hAB, out_addr=0 stable for all 5 cycles; on release, one transfer, then (1, reg1).
- Capture point:
  - Stimulus: write reg1=8'h5C while in SEND0 of pair 0, after reg1=8'h00 was captured in FETCH.
  - Response: beat addr 1 carries 8'h00; a second sweep carries 8'h5C.
- start while busy:
  - Stimulus: pulse start during SEND1 of pair 2.
  - Response: sweep continues unchanged; exactly one done; no restart.
- Abort:
  - Stimulus: abort=1 together with out_ready=1 in SEND0 of pair 1.
  - Response: next cycle IDLE; out_valid=0, busy=0, done never asserted; a following start streams again from addr 0.
- Async reset mid-sweep:
  - Stimulus: drop rst between clock edges during SEND1 of pair 3.
  - Response: out_valid, busy and done go to 0 immediately without a clock; ra1=0, ra2=1; after release, start gives a full sweep from addr 0.

Source files
------------

// File: rtl/regfile_dump_reader_if.sv
// Stream interface for (address, data) beats leaving the register-file sweeper.
interface regfile_dump_reader_if #(
  parameter int unsigned N = 8,
  parameter int unsigned M = 3
);
  logic [N-1:0] out_data;
  logic [M-1:0] out_addr;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output out_data,
    output out_addr,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_addr,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/regfile_dump_reader.sv
// Read-side sweeper for a 2-read/1-write register file: reads registers in
// even/odd pairs and streams each value out as an (address, data) beat.
module regfile_dump_reader #(
  parameter int unsigned N = 8,
  parameter int unsigned M = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic [M-1:0]          ra1,
  output logic [M-1:0]          ra2,
  input  logic [N-1:0]          rd1,
  input  logic [N-1:0]          rd2,
  regfile_dump_reader_if.master ob,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {StIdle, StFetch, StSend0, StSend1, StDone} state_e;

  // Address of the last (odd) register; the sweep ends after its beat.
  localparam logic [M-1:0] LastOdd = {M{1'b1}};

  state_e       state_q;
  logic [M-1:0] ptr_q;
  logic [N-1:0] buf0_q;
  logic [N-1:0] buf1_q;
  logic [M-1:0] ptr_odd;

  // ptr is always even, so +1 never wraps.
  assign ptr_odd = ptr_q + M'(1);
  assign ra1     = ptr_q;
  assign ra2     = ptr_odd;

  // Sweep FSM: capture a pair in FETCH, then offer its two beats.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      buf0_q  <= '0;
      buf1_q  <= '0;
    end else if (abort && state_q != StIdle) begin
      // Abort wins over a simultaneous handshake; the beat is dropped.
      state_q <= StIdle;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StFetch;
            ptr_q   <= '0;
          end
        end
        StFetch: begin
          // Only sampling point: later writes to this pair are not seen.
          buf0_q  <= rd1;
          buf1_q  <= rd2;
          state_q <= StSend0;
        end
        StSend0: begin
          if (ob.out_ready) begin
            state_q <= StSend1;
          end
        end
        StSend1: begin
          if (ob.out_ready) begin
            if (ptr_odd == LastOdd) begin
              state_q <= StDone;
            end else begin
              ptr_q   <= ptr_q + M'(2);
              state_q <= StFetch;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          ptr_q   <= '0;
        end
        default: begin
          state_q <= StIdle;
          ptr_q   <= '0;
        end
      endcase
    end
  end

  // Outputs decode only flop state, so they are glitch-free and read 0 when idle.
  always_comb begin
    ob.out_valid = 1'b0;
    ob.out_data  = '0;
    ob.out_addr  = '0;
    case (state_q)
      StSend0: begin
        ob.out_valid = 1'b1;
        ob.out_data  = buf0_q;
        ob.out_addr  = ptr_q;
      end
      StSend1: begin
        ob.out_valid = 1'b1;
        ob.out_data  = buf1_q;
        ob.out_addr  = ptr_odd;
      end
      default: ;
    endcase
  end

  // Status flags.
  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StDone);
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader with a behavioural register file.
module tb_regfile_dump_reader;

  localparam int unsigned N = 8;
  localparam int unsigned M = 3;

  logic         clk;
  logic         rst;
  logic         start;
  logic         abort;
  logic [M-1:0] ra1;
  logic [M-1:0] ra2;
  logic [N-1:0] rd1;
  logic [N-1:0] rd2;
  logic         busy;
  logic         done;
  logic [N-1:0] regs [8];

  int n_checks;
  int n_fail;

  regfile_dump_reader_if #(.N(N), .M(M)) ob ();

  regfile_dump_reader #(.N(N), .M(M)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .abort (abort),
    .ra1   (ra1),
    .ra2   (ra2),
    .rd1   (rd1),
    .rd2   (rd2),
    .ob    (ob),
    .busy  (busy),
    .done  (done)
  );

  // Combinational read ports of the modelled register file.
  assign rd1 = regs[ra1];
  assign rd2 = regs[ra2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full sweep with out_ready high; optional start pulse at cycle start_at.
  // Cycle c counts from the edge that sampled start: pair p has FETCH at
  // c=3p+1, beats at 3p+2 and 3p+3; DONE at 13, then idle.
  task automatic sweep(input int start_at);
    logic exp_v;
    int   exp_a;
    ob.out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      exp_v = (c <= 12) && (c % 3 != 1);
      exp_a = 2 * ((c - 1) / 3) + ((c % 3 == 0) ? 1 : 0);
      check($sformatf("valid c%0d", c), 32'(ob.out_valid), 32'(exp_v));
      if (exp_v) begin
        check($sformatf("addr c%0d", c), 32'(ob.out_addr), 32'(exp_a));
        check($sformatf("data c%0d", c), 32'(ob.out_data), 32'(regs[exp_a]));
      end else begin
        check($sformatf("data0 c%0d", c), 32'(ob.out_data), 32'h0);
      end
      if (c <= 10 && c % 3 == 1) begin
        check($sformatf("ra1 c%0d", c), 32'(ra1), 32'(2 * ((c - 1) / 3)));
        check($sformatf("ra2 c%0d", c), 32'(ra2), 32'(2 * ((c - 1) / 3) + 1));
      end
      check($sformatf("done c%0d", c), 32'(done), 32'(c == 13));
      check($sformatf("busy c%0d", c), 32'(busy), 32'(c <= 13));
      if (c == start_at) start = 1'b1;
      tick();
      start = 1'b0;
    end
  endtask

  task automatic wait_done(input string tag, input int bound);
    logic seen;
    seen = 1'b0;
    ob.out_ready = 1'b1;
    for (int i = 0; i < bound && !seen; i++) begin
      if (done) seen = 1'b1;
      tick();
    end
    check(tag, 32'(seen), 32'h1);
    tick();
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst          = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
    ob.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) regs[i] = 8'h10 + 8'(i);

    // Reset state.
    #2;
    check("rst valid", 32'(ob.out_valid), 32'h0);
    check("rst busy", 32'(busy), 32'h0);
    check("rst done", 32'(done), 32'h0);
    check("rst ra1", 32'(ra1), 32'h0);
    check("rst ra2", 32'(ra2), 32'h1);
    check("rst data", 32'(ob.out_data), 32'h0);
    check("rst addr", 32'(ob.out_addr), 32'h0);
    #10;
    rst = 1'b1;
    tick();

    // Basic sweep.
    sweep(0);

    // Backpressure in SEND0 of pair 0.
    regs[0] = 8'hAB;
    ob.out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp valid", 32'(ob.out_valid), 32'h1);
      check("bp data", 32'(ob.out_data), 32'hAB);
      check("bp addr", 32'(ob.out_addr), 32'h0);
      tick();
    end
    ob.out_ready = 1'b1;
    check("bp rel data", 32'(ob.out_data), 32'hAB);
    tick();
    check("bp next addr", 32'(ob.out_addr), 32'h1);
    check("bp next data", 32'(ob.out_data), 32'h11);
    wait_done("bp done", 20);

    // Capture point: write reg1 after FETCH of pair 0.
    regs[1] = 8'h00;
    ob.out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    regs[1] = 8'h5C;
    ob.out_ready = 1'b1;
    tick();
    check("cap addr", 32'(ob.out_addr), 32'h1);
    check("cap old data", 32'(ob.out_data), 32'h00);
    wait_done("cap done", 20);
    ob.out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("cap2 addr", 32'(ob.out_addr), 32'h1);
    check("cap2 new data", 32'(ob.out_data), 32'h5C);
    wait_done("cap2 done", 20);

    // start during SEND1 of pair 2 is ignored.
    sweep(9);

    // Abort with out_ready in SEND0 of pair 1.
    ob.out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("ab pre addr", 32'(ob.out_addr), 32'h2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("ab valid", 32'(ob.out_valid), 32'h0);
      check("ab busy", 32'(busy), 32'h0);
      check("ab done", 32'(done), 32'h0);
      tick();
    end
    sweep(0);

    // Async reset during SEND1 of pair 3.
    ob.out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    check("ar pre addr", 32'(ob.out_addr), 32'h7);
    #2;
    rst = 1'b0;
    #1;
    check("ar valid", 32'(ob.out_valid), 32'h0);
    check("ar busy", 32'(busy), 32'h0);
    check("ar done", 32'(done), 32'h0);
    check("ar ra1", 32'(ra1), 32'h0);
    check("ar ra2", 32'(ra2), 32'h1);
    @(posedge clk);
    #3;
    check("ar held done", 32'(done), 32'h0);
    rst = 1'b1;
    tick();
    sweep(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
